// File: rtl/push_debounce.sv
// push_debounce: synchronises, debounces and edge-detects four active-low push buttons,
// with optional auto-repeat of the press pulse while a button is held.
module push_debounce #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] PUSH_IN,
    output logic [3:0] PUSH_LVL,
    output logic [3:0] PUSH_PRESS,
    output logic [3:0] PUSH_REL,
    output logic       PUSH_ANY
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_t;

    logic [3:0]    sync1, sync2, diff, rise, fall, tick;
    logic [DW-1:0] deb_cnt [4];
    logic [DW-1:0] deb_cnt_nx [4];
    logic [RW-1:0] rpt_cnt [4];
    logic [RW-1:0] rpt_cnt_nx [4];
    rpt_t          state [4];
    rpt_t          state_nx [4];

    assign diff     = ~sync2 ^ PUSH_LVL;
    assign PUSH_ANY = |PUSH_LVL;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rise[i]       = diff[i] && deb_cnt[i] == DEB_MAX && !PUSH_LVL[i];
            fall[i]       = diff[i] && deb_cnt[i] == DEB_MAX && PUSH_LVL[i];
            deb_cnt_nx[i] = (diff[i] && deb_cnt[i] != DEB_MAX) ? deb_cnt[i] + 1'b1 : '0;
            state_nx[i]   = state[i];
            rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
            tick[i]       = 1'b0;
            case (state[i])
                IDLE: begin
                    rpt_cnt_nx[i] = '0;
                    if (rise[i] && REPEAT_EN != 0) state_nx[i] = DELAY;
                end
                DELAY: if (rpt_cnt[i] == DLY_MAX) begin
                    tick[i]       = 1'b1;
                    state_nx[i]   = RPT;
                    rpt_cnt_nx[i] = '0;
                end
                RPT: if (rpt_cnt[i] == PER_MAX) begin
                    tick[i]       = 1'b1;
                    rpt_cnt_nx[i] = '0;
                end
                default: state_nx[i] = IDLE;
            endcase
            // a release in the same cycle as a repeat tick suppresses the tick
            if (fall[i]) begin
                state_nx[i]   = IDLE;
                rpt_cnt_nx[i] = '0;
                tick[i]       = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1      <= 4'hF;
            sync2      <= 4'hF;
            PUSH_LVL   <= '0;
            PUSH_PRESS <= '0;
            PUSH_REL   <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
                rpt_cnt[i] <= '0;
                state[i]   <= IDLE;
            end
        end else begin
            sync1      <= PUSH_IN;
            sync2      <= sync1;
            PUSH_LVL   <= PUSH_LVL ^ (rise | fall);
            PUSH_PRESS <= rise | tick;
            PUSH_REL   <= fall;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= deb_cnt_nx[i];
                rpt_cnt[i] <= rpt_cnt_nx[i];
                state[i]   <= state_nx[i];
            end
        end
    end
endmodule

// File: tb/tb_push_debounce.sv
// tb_push_debounce: directed table-driven and hand-sequenced checks of push_debounce
// with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_push_debounce;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] PUSH_IN = 4'hF;
    logic [3:0] PUSH_LVL, PUSH_PRESS, PUSH_REL;
    logic       PUSH_ANY;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       rst;
        logic [3:0] in, lvl, press, rel;
    } vec_t;
    vec_t tbl[$];

    push_debounce #(.DEB_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .CLK(CLK), .RST(RST), .PUSH_IN(PUSH_IN), .PUSH_LVL(PUSH_LVL),
        .PUSH_PRESS(PUSH_PRESS), .PUSH_REL(PUSH_REL), .PUSH_ANY(PUSH_ANY)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic r, input logic [3:0] i, l, p, e, input int n);
        repeat (n) tbl.push_back('{r, i, l, p, e});
    endtask

    task automatic check(input string name, input logic [3:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // drive inputs, then sample just after the following rising edge
    task automatic step(input logic r, input logic [3:0] i);
        RST     = r;
        PUSH_IN = i;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] l, p, e);
        check({tag, ".lvl"}, PUSH_LVL, l);
        check({tag, ".press"}, PUSH_PRESS, p);
        check({tag, ".rel"}, PUSH_REL, e);
        check({tag, ".any"}, {3'b0, PUSH_ANY}, {3'b0, |l});
    endtask

    task automatic reset_idle();
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
    endtask

    initial begin
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        add(0, 4'hE, 4'h0, 4'h0, 4'h0, 5);
        add(0, 4'hE, 4'h1, 4'h1, 4'h0, 1);
        add(0, 4'hE, 4'h1, 4'h0, 4'h0, 2);
        add(0, 4'hF, 4'h1, 4'h0, 4'h0, 5);
        add(0, 4'hF, 4'h0, 4'h0, 4'h1, 1);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(0, 4'h0, 4'hF, 4'hF, 4'h0, 1);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 1);
        add(0, 4'h2, 4'hF, 4'h0, 4'h0, 5);
        add(0, 4'h2, 4'hD, 4'h0, 4'h2, 1);
        add(0, 4'h2, 4'hD, 4'h0, 4'h0, 2);
        add(0, 4'h2, 4'hD, 4'hD, 4'h0, 1);
        add(0, 4'h2, 4'hD, 4'h0, 4'h0, 1);
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].in);
            expect_out($sformatf("tbl%0d", k), tbl[k].lvl, tbl[k].press, tbl[k].rel);
        end

        reset_idle();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, k < 3 ? 4'hD : 4'hF);
                expect_out("bounce", 4'h0, 4'h0, 4'h0);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 4'hD);
            expect_out("bounce_hold", k == 6 ? 4'h2 : 4'h0, k == 6 ? 4'h2 : 4'h0, 4'h0);
        end

        reset_idle();
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 4'hB);
            expect_out("rpt_press", k == 6 ? 4'h4 : 4'h0, k == 6 ? 4'h4 : 4'h0, 4'h0);
        end
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, k >= 35 ? 4'hF : 4'hB);
            expect_out($sformatf("rpt_t0+%0d", k), k < 40 ? 4'h4 : 4'h0,
                       (k >= 10 && k % 5 == 0 && k != 40) ? 4'h4 : 4'h0, k == 40 ? 4'h4 : 4'h0);
        end

        reset_idle();
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 4'h7);
            expect_out("rst_press", k == 6 ? 4'h8 : 4'h0, k == 6 ? 4'h8 : 4'h0, 4'h0);
        end
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 4'h7);
            expect_out("rst_rpt", 4'h8, k == 10 ? 4'h8 : 4'h0, 4'h0);
        end
        step(1'b1, 4'h7);
        expect_out("rst_in1", 4'h0, 4'h0, 4'h0);
        step(1'b1, 4'h7);
        expect_out("rst_in2", 4'h0, 4'h0, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 4'h7);
            expect_out($sformatf("rst_after%0d", k), k >= 6 ? 4'h8 : 4'h0,
                       (k == 6 || k == 16) ? 4'h8 : 4'h0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
